// File: rtl/dec_checker.sv
// dec_checker: scans decrypted bytes in dec_memory for plaintext validity.
// Optional early abort on first bad byte: DEC_CHECKER_EARLY_ABORT_EN.
module dec_checker #(
  parameter int MSG_LEN = 32,
  parameter int ADDR_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        data_in,
  output logic [ADDR_W-1:0] address,
  output logic              task_on,
  output logic              fin_strobe,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [ADDR_W:0]   LAST = (ADDR_W+1)'(MSG_LEN - 1);
  localparam logic [ADDR_W-1:0] NONE = '1;

  logic [1:0]        state_q;
  logic [1:0]        state_d;
  logic [ADDR_W:0]   addr_q;
  logic              chk_vld_q;
  logic [ADDR_W-1:0] chk_addr_q;
  logic              err_q;
  logic [ADDR_W-1:0] first_q;
  logic              byte_ok;
  logic              bad;
  logic              err_d;
  logic [ADDR_W-1:0] first_d;

  // classify the byte returned for the previously issued address
  always_comb begin
    byte_ok = (data_in == 8'h20) ||
              ((data_in >= 8'h61) && (data_in <= 8'h7A));
    bad     = chk_vld_q && !byte_ok;
    err_d   = err_q | bad;
    first_d = err_q ? first_q : (bad ? chk_addr_q : NONE);
  end

  // next-state selection
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = READ;
      READ:    if (addr_q == LAST) state_d = DRAIN;
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
`ifdef DEC_CHECKER_EARLY_ABORT_EN
    if (((state_q == READ) || (state_q == DRAIN)) && bad)
      state_d = DONE;
`endif
  end

  // state, read pipeline, error tracking and verdict registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      chk_vld_q  <= 1'b0;
      chk_addr_q <= '0;
      err_q      <= 1'b0;
      first_q    <= NONE;
      pass       <= 1'b0;
      fail_addr  <= NONE;
    end else begin
      state_q    <= state_d;
      chk_vld_q  <= (state_q == READ) && (state_d != DONE);
      chk_addr_q <= addr_q[ADDR_W-1:0];
      if ((state_q == IDLE) && start) begin
        addr_q  <= '0;
        err_q   <= 1'b0;
        first_q <= NONE;
      end else begin
        err_q   <= err_d;
        first_q <= first_d;
        if ((state_q == READ) && (state_d == READ))
          addr_q <= addr_q + 1'b1;
      end
      if ((state_d == DONE) && (state_q != DONE)) begin
        pass      <= !err_d;
        fail_addr <= first_d;
      end
    end
  end

  // status outputs decoded from the state
  always_comb begin
    address    = addr_q[ADDR_W-1:0];
    task_on    = (state_q == READ) || (state_q == DRAIN);
    fin_strobe = (state_q == DONE);
  end

endmodule

// File: tb/tb_dec_checker.sv
// tb_dec_checker: directed vectors plus cycle model for dec_checker.
// Expectations adapt when DEC_CHECKER_EARLY_ABORT_EN is defined.
module tb_dec_checker;

  localparam int ML = 32;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] q;
  logic [7:0] address;
  logic       task_on;
  logic       fin_strobe;
  logic       pass;
  logic [7:0] fail_addr;

  logic       start2;
  logic [7:0] q2;
  logic [7:0] address2;
  logic       task_on2;
  logic       fin2;
  logic       pass2;
  logic [7:0] fail2;

  logic [7:0] mem  [0:ML-1];
  logic [7:0] mem2 [0:255];

  int total  = 0;
  int passed = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  dec_checker #(.MSG_LEN(ML), .ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .data_in(q),
    .address(address), .task_on(task_on), .fin_strobe(fin_strobe),
    .pass(pass), .fail_addr(fail_addr)
  );

  dec_checker #(.MSG_LEN(256), .ADDR_W(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .data_in(q2),
    .address(address2), .task_on(task_on2), .fin_strobe(fin2),
    .pass(pass2), .fail_addr(fail2)
  );

  always @(posedge clk) q  <= mem[address[4:0]];
  always @(posedge clk) q2 <= mem2[address2];

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    else
      passed++;
  endtask

  function automatic bit ok_byte(logic [7:0] b);
    return (b == 8'h20) || (b >= 8'h61 && b <= 8'h7A);
  endfunction

  function automatic int first_bad();
    for (int i = 0; i < ML; i++)
      if (!ok_byte(mem[i])) return i;
    return -1;
  endfunction

  // cycle index after start at which fin_strobe is high
  function automatic int fin_k(int fb);
`ifdef DEC_CHECKER_EARLY_ABORT_EN
    if (fb >= 0) return fb + 2;
`endif
    return ML + 1 + 0 * fb;
  endfunction

  function automatic int last_a(int fb);
`ifdef DEC_CHECKER_EARLY_ABORT_EN
    if (fb >= 0) return (fb + 1 < ML - 1) ? fb + 1 : ML - 1;
`endif
    return ML - 1 + 0 * fb;
  endfunction

  function automatic int exp_lat(int fb);
    return fin_k(fb) + 1;
  endfunction

  // behavioural model
  bit         scan_on = 1'b0;
  int         k = 0;
  int         fb_q = -1;
  logic [7:0] exp_addr = 8'h00;
  logic       exp_pass = 1'b0;
  logic [7:0] exp_fail = 8'hFF;

  always @(posedge clk) begin
    if (!rst_n) begin
      scan_on  <= 1'b0;
      k        <= 0;
      exp_addr <= 8'h00;
      exp_pass <= 1'b0;
      exp_fail <= 8'hFF;
    end else if (!scan_on) begin
      if (start) begin
        scan_on  <= 1'b1;
        k        <= 0;
        exp_addr <= 8'h00;
        fb_q     <= first_bad();
      end
    end else begin
      k <= k + 1;
      if (k + 1 <= last_a(fb_q)) exp_addr <= 8'(k + 1);
      if (k + 1 == fin_k(fb_q)) begin
        exp_pass <= (fb_q < 0);
        exp_fail <= (fb_q < 0) ? 8'hFF : 8'(fb_q);
      end
      if (k + 1 > fin_k(fb_q)) scan_on <= 1'b0;
    end
  end

  // per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("task_on", task_on, scan_on && (k < fin_k(fb_q)));
      check("fin_strobe", fin_strobe, scan_on && (k == fin_k(fb_q)));
      check("address", address, exp_addr);
      check("pass", pass, exp_pass);
      check("fail_addr", fail_addr, exp_fail);
    end
  end

  task automatic load_str(string s);
    for (int i = 0; i < ML; i++) mem[i] = s[i];
  endtask

  task automatic fill(logic [7:0] b);
    for (int i = 0; i < ML; i++) mem[i] = b;
  endtask

  task automatic run_scan(string nm, int lat, bit p, logic [7:0] fa);
    int cyc;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!fin_strobe && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    check({nm, "_lat"}, cyc, lat);
    check({nm, "_pass"}, pass, p);
    check({nm, "_faddr"}, fail_addr, fa);
    @(negedge clk);
  endtask

  task automatic count_fins(string nm, int n, int exp);
    int c = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (fin_strobe) c++;
    end
    check(nm, c, exp);
  endtask

  int seen [0:255];
  int cyc2;
  int badcnt;

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    start2 = 1'b0;
    fill(8'h61);
    for (int i = 0; i < 256; i++) mem2[i] = 8'h20;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("rst_addr", address, 8'h00);
    check("rst_task_on", task_on, 1'b0);
    check("rst_fin", fin_strobe, 1'b0);
    check("rst_pass", pass, 1'b0);
    check("rst_faddr", fail_addr, 8'hFF);
    chk_en = 1'b1;

    load_str("the quick brown fox jumps over a");
    run_scan("fox", 34, 1'b1, 8'hFF);

    mem[5]  = 8'h41;
    mem[20] = 8'h00;
`ifdef DEC_CHECKER_EARLY_ABORT_EN
    run_scan("two_bad", 8, 1'b0, 8'd5);
`else
    run_scan("two_bad", 34, 1'b0, 8'd5);
`endif

    fill(8'h61); mem[3] = 8'h60;
    run_scan("b60", exp_lat(3), 1'b0, 8'd3);
    fill(8'h7A); mem[10] = 8'h7B;
    run_scan("b7b", exp_lat(10), 1'b0, 8'd10);
    fill(8'h20); mem[0] = 8'h1F;
    run_scan("b1f", exp_lat(0), 1'b0, 8'd0);
    fill(8'h7A); mem[31] = 8'h40;
    run_scan("last", exp_lat(31), 1'b0, 8'd31);
    fill(8'h7A); mem[0] = 8'h61; mem[15] = 8'h20; mem[31] = 8'h61;
    run_scan("bok", 34, 1'b1, 8'hFF);

    // reset mid-scan abandons the scan
    load_str("the quick brown fox jumps over a");
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_task_on", task_on, 1'b0);
    count_fins("midrst_nofin", 40, 0);
    run_scan("after_rst", 34, 1'b1, 8'hFF);

    // second start mid-scan is ignored
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    count_fins("restart_one_fin", 45, 1);

    // start coinciding with reset is ignored
    @(negedge clk);
    start = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("start_in_rst", task_on, 1'b0);
    count_fins("start_in_rst_nofin", 40, 0);

    // full 256-byte message on the second instance
    for (int i = 0; i < 256; i++) seen[i] = 0;
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    cyc2 = 1;
    while (!fin2 && cyc2 < 600) begin
      if (cyc2 <= 256) seen[address2]++;
      @(negedge clk);
      cyc2++;
    end
    badcnt = 0;
    for (int i = 0; i < 256; i++) if (seen[i] != 1) badcnt++;
    check("m256_addr_once", badcnt, 0);
    check("m256_lat", cyc2, 258);
    check("m256_pass", pass2, 1'b1);
    check("m256_faddr", fail2, 8'hFF);
    check("m256_hold", address2, 8'hFF);
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dec_checker.md
DEC_CHECKER -- requirements
Module: dec_checker

Interface
REQ-001 Parameter: MSG_LEN, default 32, number of decrypted bytes to scan (1..256).
REQ-002 Parameter: ADDR_W, default 8, dec_memory address width.
REQ-003 Port: clk  input  1  system clock; every register updates on its rising edge.
REQ-004 Port: rst_n  input  1  reset, synchronous and active-low.
REQ-005 Port: start  input  1  one-cycle strobe that begins a scan; driven by task2b fin_strobe.
REQ-006 Port: data_in  input  8  dec_memory q; valid one cycle after the address is sampled.
REQ-007 Port: address  output  ADDR_W  read address to dec_memory; this block never writes.
REQ-008 Port: task_on  output  1  high while a scan is in progress.
REQ-009 Port: fin_strobe  output  1  one-cycle pulse when a scan completes.
REQ-010 Port: pass  output  1  verdict of the last completed scan; 1 = plaintext valid.
REQ-011 Port: fail_addr  output  ADDR_W  address of the first invalid byte in the last scan; all-ones when none.

Function
REQ-012 The state machine SHALL have states IDLE, READ, DRAIN and DONE.
REQ-013 In IDLE, start=1 at edge E SHALL move to READ, clear the internal error flag, and set address to 0.
REQ-014 task_on SHALL be 1 in READ and DRAIN only.
REQ-015 In READ, address SHALL increment by 1 per cycle, presenting 0..MSG_LEN-1 on cycles E+1..E+MSG_LEN.
REQ-016 Byte i SHALL be sampled from data_in at edge E+2+i. Reads are pipelined: address i+1 is issued while byte i is fetched.
REQ-017 A byte is valid iff it equals 8'h20 (space) or lies in 8'h61..8'h7A inclusive ('a'..'z'); all other values are invalid.
REQ-018 On the first invalid byte, the block SHALL latch that byte's address into an internal first-error register; later invalid bytes SHALL not overwrite it.
REQ-019 After address MSG_LEN-1 is issued, READ SHALL go to DRAIN for one cycle to check the last byte, then go to DONE.
REQ-020 In DONE, fin_strobe SHALL be 1 for exactly one cycle (cycle E+MSG_LEN+2).
REQ-021 pass and fail_addr SHALL update in the same cycle that fin_strobe rises. Both SHALL hold their values until the next scan's fin_strobe.
REQ-022 DONE SHALL return to IDLE unconditionally on the next edge.
REQ-023 start while task_on=1 or in DONE SHALL be ignored.
REQ-024 The address counter SHALL be ADDR_W+1 bits internally, so MSG_LEN=256 terminates without wrap-around. The address output SHALL be the low ADDR_W bits.
REQ-025 Outside READ, address SHALL hold its last value.

Reset
REQ-026 rst_n=0 sampled at any edge SHALL force IDLE and set address=0, task_on=0, fin_strobe=0, pass=0, and fail_addr all-ones.
REQ-027 Reset during a scan SHALL abandon that scan without a fin_strobe. A start must be issued again after reset releases.
REQ-028 A start that coincides with rst_n=0 SHALL be ignored.

Configuration
REQ-029 Macro DEC_CHECKER_EARLY_ABORT_EN:
- Defined: the first invalid byte SHALL end READ and DRAIN immediately and go to DONE on the next edge. fin_strobe follows on that DONE cycle, with pass=0.
- Undefined: all MSG_LEN bytes are always scanned, and latency is always MSG_LEN+2 cycles from start.

Verification
REQ-030 MSG_LEN=32, memory holds "the quick brown fox jumps over a" → fin_strobe at E+34, pass=1, fail_addr=8'hFF.
REQ-031 Byte 5=8'h41 ('A') and byte 20=8'h00, macro undefined → fin_strobe at E+34, pass=0, fail_addr=5.
REQ-032 Same data with DEC_CHECKER_EARLY_ABORT_EN defined → fin_strobe at E+8, pass=0, fail_addr=5, and address never exceeds 6.
REQ-033 Boundary bytes 8'h60, 8'h7B and 8'h1F each flag as invalid, while 8'h61, 8'h7A and 8'h20 pass.
REQ-034 rst_n=0 at cycle E+10 → task_on=0 and no fin_strobe. A new start then gives a correct verdict. A second start at E+5 mid-scan → ignored, and exactly one fin_strobe occurs.
REQ-035 MSG_LEN=256, all bytes 8'h20 → addresses 0..255 issued once each, fin_strobe at E+258, pass=1.
